weight_stream_scheduler: RTL

WEIGHT_STREAM_SCHEDULER -- requirements
Module: weight_stream_scheduler

---
 rtl/weight_stream_pkg.sv | 17 +
 rtl/weight_stream_fifo.sv | 58 +++++
 rtl/weight_stream_scheduler.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/weight_stream_pkg.sv
// Shared constants and FSM state type for the weight stream scheduler.
package weight_stream_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH  = 128;
    localparam int unsigned DEFAULT_DEPTH       = 576;
    localparam int unsigned DEFAULT_ROM_LATENCY = 2;
    localparam int unsigned DEFAULT_PASS_WIDTH  = 8;
    localparam int unsigned DEFAULT_FIFO_DEPTH  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/weight_stream_fifo.sv
// Synchronous first-word-fall-through buffer between the ROM pipeline and the
// consumer; writes into a full buffer and reads from an empty one are dropped.
module weight_stream_fifo #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  valid,
    output logic [CNT_WIDTH-1:0]  count
);

    localparam int unsigned PTR_WIDTH = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic                  do_wr;
    logic                  do_rd;

    assign do_wr   = wr_en && (count != CNT_WIDTH'(FIFO_DEPTH));
    assign do_rd   = rd_en && (count != '0);
    assign valid   = (count != '0);
    assign rd_data = mem[rd_ptr];

    // Storage array carries no reset; only pointers and occupancy do.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= (wr_ptr == PTR_WIDTH'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_WIDTH'(1);
            end
            if (do_rd) begin
                rd_ptr <= (rd_ptr == PTR_WIDTH'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_WIDTH'(1);
            end
            unique case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/weight_stream_scheduler.sv
// Streams a weight ROM num_passes times into a flow-controlled output port.
// Optional WEIGHT_STREAM_SCHEDULER_PERF_EN adds a saturating stall_cycles counter.
module weight_stream_scheduler
    import weight_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH       = DEFAULT_DEPTH,
    parameter int unsigned ADDR_WIDTH  = $clog2(DEPTH) + 1,
    parameter int unsigned ROM_LATENCY = DEFAULT_ROM_LATENCY,
    parameter int unsigned PASS_WIDTH  = DEFAULT_PASS_WIDTH,
    parameter int unsigned FIFO_DEPTH  = DEFAULT_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [PASS_WIDTH-1:0] num_passes,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_ce,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ready
`ifdef WEIGHT_STREAM_SCHEDULER_PERF_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);

    localparam int unsigned CNT_WIDTH = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned INF_WIDTH = $clog2(ROM_LATENCY + 1);

    if (FIFO_DEPTH < ROM_LATENCY + 2) begin : g_depth_check
        $error("weight_stream_scheduler: FIFO_DEPTH must be at least ROM_LATENCY+2");
    end

    state_t                 state;
    state_t                 next_state;
    logic [ROM_LATENCY-1:0] rd_pipe;
    logic [INF_WIDTH-1:0]   inflight;
    logic [CNT_WIDTH-1:0]   occ;
    logic [PASS_WIDTH-1:0]  pass_cnt;
    logic [PASS_WIDTH-1:0]  num_q;
    logic                   room;
    logic                   issue;
    logic                   pop;
    logic                   last_addr;
    logic                   last_pass;
    logic                   accept;

    assign rom_ce    = 1'b1;
    assign pop       = data_out_valid && data_out_ready;
    assign last_addr = (rom_addr == ADDR_WIDTH'(DEPTH - 1));
    assign last_pass = (pass_cnt == num_q - PASS_WIDTH'(1));
    assign accept    = (state == ST_IDLE) && start;

    // Reads in flight plus buffered beats bound the buffer space still needed.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(ROM_LATENCY); i++) begin
            inflight = inflight + INF_WIDTH'(rd_pipe[i]);
        end
        room = (32'(inflight) + 32'(occ)) < FIFO_DEPTH;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        issue      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = (num_passes == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                issue = room;
                if (room && last_addr && last_pass) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && (inflight == '0) && (occ == CNT_WIDTH'(1))) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Address/pass sequencing, read-valid pipeline and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr <= '0;
            pass_cnt <= '0;
            num_q    <= '0;
            rd_pipe  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            busy    <= (next_state != ST_IDLE);
            done    <= (next_state == ST_DONE);
            rd_pipe <= (rd_pipe << 1) | ROM_LATENCY'(issue);
            if (accept) begin
                rom_addr <= '0;
                pass_cnt <= '0;
                num_q    <= num_passes;
            end else if (issue) begin
                if (last_addr) begin
                    rom_addr <= '0;
                    pass_cnt <= pass_cnt + PASS_WIDTH'(1);
                end else begin
                    rom_addr <= rom_addr + ADDR_WIDTH'(1);
                end
            end
        end
    end

    weight_stream_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (rd_pipe[ROM_LATENCY-1]),
        .wr_data (rom_q),
        .rd_en   (pop),
        .rd_data (data_out),
        .valid   (data_out_valid),
        .count   (occ)
    );

`ifdef WEIGHT_STREAM_SCHEDULER_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            stall_cycles <= '0;
        end else if (data_out_valid && !data_out_ready && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule
